mem_port_arbiter: RTL and testbench

// Shares the single external memory bus between instruction fetch (IF) and load/store (LS).
// LS requests come from the decoded mem_r/mem_w/mem_sz fields.
// Up to DEPTH bus transactions may be in flight; an owner FIFO routes in-order responses back.

---
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory bus between fetch and load/store, in-order owner FIFO routes responses
// Optional MEM_ARB_RR_EN: round-robin on contested cycles instead of LS priority with anti-starvation.
module mem_port_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic        ls_we,
    input  logic [1:0]  ls_sz,
    output logic        ls_rsp_valid,
    output logic [31:0] ls_rsp_data,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_we,
    output logic [1:0]  bus_sz,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_data,
    output logic        err
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] owner_mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             contested;
    logic             grant_ls;
    logic             grant_if;
    logic             if_hs;
    logic             ls_hs;
    logic             push;
    logic             pop;
    logic             head_owner;

`ifdef MEM_ARB_RR_EN
    logic rr_ls;
`else
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_cnt;
`endif

    always_comb begin
        fifo_full  = (count == CW'(DEPTH));
        fifo_empty = (count == '0);
        contested  = if_req_valid && ls_req_valid;
`ifdef MEM_ARB_RR_EN
        grant_ls   = ls_req_valid && !(contested && !rr_ls);
`else
        grant_ls   = ls_req_valid && !(contested && (starve_cnt == SW'(STARVE_MAX)));
`endif
        grant_if   = if_req_valid && !grant_ls;

        // A full FIFO stalls requests even when a response pops this cycle.
        bus_req_valid = !rst && (grant_if || grant_ls) && !fifo_full;
        if_req_ready  = !rst && grant_if && bus_req_ready && !fifo_full;
        ls_req_ready  = !rst && grant_ls && bus_req_ready && !fifo_full;
        bus_addr      = grant_ls ? ls_addr : if_addr;
        bus_wdata     = grant_ls ? ls_wdata : 32'h0;
        bus_we        = grant_ls && ls_we;
        bus_sz        = grant_ls ? ls_sz : 2'd2;

        if_hs      = if_req_valid && if_req_ready;
        ls_hs      = ls_req_valid && ls_req_ready;
        push       = if_hs || ls_hs;
        head_owner = owner_mem[rd_ptr];
        pop        = !rst && bus_rsp_valid && !fifo_empty;

        if_rsp_valid = pop && !head_owner;
        ls_rsp_valid = pop && head_owner;
        if_rsp_data  = bus_rsp_data;
        ls_rsp_data  = bus_rsp_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
`ifdef MEM_ARB_RR_EN
            rr_ls  <= 1'b0;
`else
            starve_cnt <= '0;
`endif
        end else begin
            if (push) begin
                owner_mem[wr_ptr] <= ls_hs;
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (!push && pop)
                count <= count - 1'b1;
            // A response with nobody waiting for it is a protocol violation; sticky until reset.
            if (bus_rsp_valid && fifo_empty)
                err <= 1'b1;
`ifdef MEM_ARB_RR_EN
            if (contested && push)
                rr_ls <= !rr_ls;
`else
            if (if_hs)
                starve_cnt <= '0;
            else if (contested && ls_hs && (starve_cnt != SW'(STARVE_MAX)))
                starve_cnt <= starve_cnt + 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized and directed checks of mem_port_arbiter against a queue-based model
module tb_mem_port_arbiter;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;
`ifdef MEM_ARB_RR_EN
    localparam bit FIRST_LS = 1'b0;
    localparam logic [9:0] GRANT_PAT = 10'b1010101010;
`else
    localparam bit FIRST_LS = 1'b1;
    localparam logic [9:0] GRANT_PAT = 10'b0111101111;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_valid = 1'b0, if_req_ready, if_rsp_valid;
    logic [31:0] if_addr = '0, if_rsp_data;
    logic        ls_req_valid = 1'b0, ls_req_ready, ls_rsp_valid;
    logic [31:0] ls_addr = '0, ls_wdata = '0, ls_rsp_data;
    logic        ls_we = 1'b0;
    logic [1:0]  ls_sz = '0;
    logic        bus_req_valid, bus_req_ready = 1'b0, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [1:0]  bus_sz;
    logic        bus_rsp_valid = 1'b0;
    logic [31:0] bus_rsp_data = '0;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    bit q[$];
    int starve = 0;
    bit pref_ls = 1'b0;
    bit merr = 1'b0;

    mem_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_we(ls_we), .ls_sz(ls_sz),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_sz(bus_sz),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit ifv, input logic [31:0] ifa, input bit lsv, input logic [31:0] lsa,
                         input logic [31:0] lsd, input bit we, input logic [1:0] sz,
                         input bit brdy, input bit rv, input logic [31:0] rd);
        if_req_valid = ifv; if_addr = ifa;
        ls_req_valid = lsv; ls_addr = lsa; ls_wdata = lsd; ls_we = we; ls_sz = sz;
        bus_req_ready = brdy; bus_rsp_valid = rv; bus_rsp_data = rd;
    endtask

    // Called once per cycle, after inputs change on the falling edge; predicts the coming posedge.
    task automatic settle();
        bit full, gls, gif, ev, own, hs_if, hs_ls;
        #1;
        if (rst) begin
            chk("rst_if_ready", {31'b0, if_req_ready}, 0);
            chk("rst_ls_ready", {31'b0, ls_req_ready}, 0);
            chk("rst_bus_valid", {31'b0, bus_req_valid}, 0);
            chk("rst_if_rsp", {31'b0, if_rsp_valid}, 0);
            chk("rst_ls_rsp", {31'b0, ls_rsp_valid}, 0);
            q.delete(); starve = 0; pref_ls = 1'b0; merr = 1'b0;
            return;
        end
        full = (q.size() == DEPTH);
`ifdef MEM_ARB_RR_EN
        gls = ls_req_valid && (!if_req_valid || pref_ls);
`else
        gls = ls_req_valid && (!if_req_valid || starve < STARVE_MAX);
`endif
        gif = if_req_valid && !gls;
        ev  = (gif || gls) && !full;
        hs_if = gif && bus_req_ready && !full;
        hs_ls = gls && bus_req_ready && !full;
        chk("bus_req_valid", {31'b0, bus_req_valid}, {31'b0, ev});
        chk("if_req_ready", {31'b0, if_req_ready}, {31'b0, hs_if});
        chk("ls_req_ready", {31'b0, ls_req_ready}, {31'b0, hs_ls});
        if (ev) begin
            chk("bus_addr", bus_addr, gls ? ls_addr : if_addr);
            chk("bus_we", {31'b0, bus_we}, {31'b0, gls && ls_we});
            chk("bus_sz", {30'b0, bus_sz}, gls ? {30'b0, ls_sz} : 32'd2);
            if (gls) chk("bus_wdata", bus_wdata, ls_wdata);
        end
        chk("err", {31'b0, err}, {31'b0, merr});
        if (bus_rsp_valid && q.size() > 0) begin
            own = q.pop_front();
            chk("if_rsp_valid", {31'b0, if_rsp_valid}, {31'b0, !own});
            chk("ls_rsp_valid", {31'b0, ls_rsp_valid}, {31'b0, own});
            chk("rsp_data", own ? ls_rsp_data : if_rsp_data, bus_rsp_data);
        end else begin
            chk("if_rsp_idle", {31'b0, if_rsp_valid}, 0);
            chk("ls_rsp_idle", {31'b0, ls_rsp_valid}, 0);
            if (bus_rsp_valid) merr = 1'b1;
        end
        if (hs_if || hs_ls) q.push_back(hs_ls);
        if (if_req_valid && ls_req_valid && (hs_if || hs_ls)) pref_ls = hs_if;
        if (hs_if) starve = 0;
        else if (hs_ls && if_req_valid && starve < STARVE_MAX) starve++;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; drive(1, 32'h4, 1, 32'h8, 0, 0, 0, 1, 0, 0); settle();
        @(negedge clk); settle();
        @(negedge clk); rst = 1'b0; drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
    endtask

    initial begin
        logic [9:0] g;

        // Reset state and IF-only fetch
        do_reset();
        @(negedge clk); drive(1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0); settle();
        chk("lit_if_addr", bus_addr, 32'h100);
        chk("lit_if_ready", {31'b0, if_req_ready}, 1);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF); settle();
        chk("lit_if_rsp_valid", {31'b0, if_rsp_valid}, 1);
        chk("lit_if_rsp_data", if_rsp_data, 32'hDEADBEEF);
        chk("lit_ls_rsp_quiet", {31'b0, ls_rsp_valid}, 0);

        // Contested request, then the loser alone
        @(negedge clk); drive(1, 32'h200, 1, 32'h300, 32'hCAFE, 1, 2'd1, 1, 0, 0); settle();
        chk("lit_first_ls_ready", {31'b0, ls_req_ready}, {31'b0, FIRST_LS});
        chk("lit_first_if_ready", {31'b0, if_req_ready}, {31'b0, !FIRST_LS});
        chk("lit_first_we", {31'b0, bus_we}, {31'b0, FIRST_LS});
        chk("lit_first_sz", {30'b0, bus_sz}, FIRST_LS ? 32'd1 : 32'd2);
        @(negedge clk); drive(FIRST_LS, 32'h200, !FIRST_LS, 32'h300, 32'hCAFE, 1, 2'd1, 1, 1, 32'h1); settle();
        chk("lit_second_if_ready", {31'b0, if_req_ready}, {31'b0, FIRST_LS});
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h2); settle();

        // Both held valid for 10 cycles with responses draining every cycle
        do_reset();
        g = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); drive(1, 32'h40 + i, 1, 32'h80 + i, i, 0, 2'd2, 1, q.size() > 0, 32'h900 + i); settle();
            g[i] = ls_req_ready;
        end
        chk("lit_grant_pattern", {22'b0, g}, {22'b0, GRANT_PAT});
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); settle();

        // Fill to DEPTH=2, third request stalls even while a response pops
        do_reset();
        @(negedge clk); drive(0, 0, 1, 32'h10, 0, 0, 2'd2, 1, 0, 0); settle();
        @(negedge clk); drive(1, 32'h20, 0, 0, 0, 0, 0, 1, 0, 0); settle();
        @(negedge clk); drive(0, 0, 1, 32'h30, 0, 0, 2'd2, 1, 0, 0); settle();
        chk("lit_full_ready", {31'b0, ls_req_ready}, 0);
        @(negedge clk); drive(0, 0, 1, 32'h30, 0, 0, 2'd2, 1, 1, 32'h11); settle();
        chk("lit_full_nobypass", {31'b0, ls_req_ready}, 0);
        chk("lit_rsp11_ls", {31'b0, ls_rsp_valid}, 1);
        chk("lit_rsp11_data", ls_rsp_data, 32'h11);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h22); settle();
        chk("lit_rsp22_if", {31'b0, if_rsp_valid}, 1);
        chk("lit_rsp22_data", if_rsp_data, 32'h22);

        // Reset with a transaction in flight, then a stray response
        @(negedge clk); drive(0, 0, 1, 32'h50, 0, 0, 2'd2, 1, 0, 0); settle();
        do_reset();
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55); settle();
        chk("lit_stray_ls", {31'b0, ls_rsp_valid}, 0);
        chk("lit_stray_if", {31'b0, if_rsp_valid}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
            chk("lit_err_sticky", {31'b0, err}, 1);
        end
        do_reset();
        chk("lit_err_cleared", {31'b0, err}, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) != 0, $urandom, $urandom,
                  $urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                  (q.size() > 0) && ($urandom_range(0, 1) == 1), $urandom);
            settle();
        end
        @(negedge clk); rst = 1'b0; drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); settle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
